// File: rtl/immediate_encoder.sv
// rtl/immediate_encoder.sv - encodes a 16-bit value into instr[10:0] immediate bits plus ImmOp
module immediate_encoder #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [15:0]          in_value,
  input  logic [1:0]           in_mode,
  input  logic                 in_scale,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [10:0]          out_field,
  output logic [3:0]           out_immop,
  output logic                 out_last,
  output logic                 out_error,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {IDLE, BEAT1, BEAT2} state_t;

  state_t               state, state_nx;
  logic                 valid_nx, last_nx, error_nx;
  logic [10:0]          field_nx;
  logic [3:0]           immop_nx;
  logic [6:0]           lo_bits, lo_bits_nx;
  logic [ERR_CNT_W-1:0] err_nx;

  logic [15:0] w;
  logic        even_ok, fits7, fits9, lc_single, lc_lo_zero;
  logic [8:0]  hi;
  logic [10:0] enc_field;
  logic [3:0]  enc_immop;
  logic        enc_last, enc_error;
  logic        fire, accept, load;

  // Encode the incoming request into its first (or only) beat.
  always_comb begin
    w          = in_scale ? {in_value[15], in_value[15:1]} : in_value;
    even_ok    = !in_scale || !in_value[0];
    fits7      = ({{9{w[6]}}, w[6:0]} == w) && even_ok;
    fits9      = ({{7{w[8]}}, w[8:0]} == w) && even_ok;
    lc_single  = ({{9{in_value[6]}}, in_value[6:0]} == in_value);
    lc_lo_zero = (in_value[6:0] == 7'd0);
    // (v - sext7(v[6:0])) >> 7 reduces to v[15:7] plus the sign of the low part.
    hi         = in_value[15:7] + {8'd0, in_value[6]};
    enc_field  = '0;
    enc_immop  = '0;
    enc_last   = 1'b1;
    enc_error  = 1'b0;
    case (in_mode)
      2'd0: begin
        enc_field = {w[6:0], 4'b0000};
        enc_immop = {1'b0, in_scale, 2'b01};
        enc_error = !fits7;
      end
      2'd1: begin
        enc_field = {w[6:2], 4'b0000, w[1:0]};
        enc_immop = {1'b0, in_scale, 2'b00};
        enc_error = !fits7;
      end
      2'd2: begin
        enc_field = {w[8:0], 2'b00};
        enc_immop = {1'b0, in_scale, 2'b10};
        enc_error = !fits9;
      end
      default: begin
        if (lc_single) begin
          enc_field = {in_value[6:0], 4'b0000};
          enc_immop = 4'b0001;
        end else begin
          enc_field = {hi, 2'b00};
          enc_immop = 4'b1010;
          enc_last  = lc_lo_zero;
        end
      end
    endcase
    if (enc_error) begin
      enc_field = '0;
      enc_immop = {2'b00, in_mode};
    end
  end

  // Handshake, next state and next output beat.
  always_comb begin
    in_ready   = !rst && ((state == IDLE) || (out_valid && out_ready && out_last));
    fire       = out_valid && out_ready;
    accept     = in_valid && in_ready;
    load       = 1'b0;
    state_nx   = state;
    valid_nx   = out_valid;
    field_nx   = out_field;
    immop_nx   = out_immop;
    last_nx    = out_last;
    error_nx   = out_error;
    lo_bits_nx = lo_bits;
    err_nx     = err_count;
    if (fire && out_error && (err_count != '1)) begin
      err_nx = err_count + ERR_CNT_W'(1);
    end
    case (state)
      IDLE: begin
        load = accept;
      end
      BEAT1: begin
        if (fire) begin
          if (!out_last) begin
            state_nx = BEAT2;
            field_nx = {lo_bits, 4'b0000};
            immop_nx = 4'b0001;
            last_nx  = 1'b1;
            error_nx = 1'b0;
          end else begin
            load = accept;
          end
        end
      end
      BEAT2: begin
        load = fire && accept;
      end
      default: ;
    endcase
    if (fire && out_last && !load) begin
      state_nx = IDLE;
      valid_nx = 1'b0;
    end
    if (load) begin
      state_nx   = BEAT1;
      valid_nx   = 1'b1;
      field_nx   = enc_field;
      immop_nx   = enc_immop;
      last_nx    = enc_last;
      error_nx   = enc_error;
      lo_bits_nx = in_value[6:0];
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_field <= '0;
      out_immop <= '0;
      out_last  <= 1'b0;
      out_error <= 1'b0;
      lo_bits   <= '0;
      err_count <= '0;
    end else begin
      state     <= state_nx;
      out_valid <= valid_nx;
      out_field <= field_nx;
      out_immop <= immop_nx;
      out_last  <= last_nx;
      out_error <= error_nx;
      lo_bits   <= lo_bits_nx;
      err_count <= err_nx;
    end
  end

endmodule

// File: tb/tb_immediate_encoder.sv
// tb/tb_immediate_encoder.sv - scoreboard bench for immediate_encoder
module tb_immediate_encoder;

  typedef struct packed {
    logic [10:0] field;
    logic [3:0]  immop;
    logic        last;
    logic        err;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_value = '0;
  logic [1:0]  in_mode = '0;
  logic        in_scale = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [10:0] out_field;
  logic [3:0]  out_immop;
  logic        out_last;
  logic        out_error;
  logic [7:0]  err_count;

  int    n_chk = 0;
  int    n_pass = 0;
  int    cyc = 0;
  int    exp_err = 0;
  bit    auto_rdy = 1'b0;
  beat_t exp_q[$];
  beat_t dir_q[$];

  immediate_encoder #(.ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value),
    .in_mode(in_mode), .in_scale(in_scale),
    .out_valid(out_valid), .out_ready(out_ready), .out_field(out_field),
    .out_immop(out_immop), .out_last(out_last), .out_error(out_error),
    .err_count(err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (auto_rdy) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic void dpush(input int field, input int immop, input bit last, input bit err);
    beat_t b;
    b.field = 11'(field);
    b.immop = 4'(immop);
    b.last  = last;
    b.err   = err;
    dir_q.push_back(b);
  endfunction

  // Reference model: value arithmetic on plain integers.
  function automatic void model_push(input logic [15:0] v, input logic [1:0] m, input logic s);
    beat_t b;
    int sv, w, lo, hi, lim;
    bit ok;
    sv = int'($signed(v));
    if (m == 2'd3) begin
      lo = int'(v & 16'h7F);
      if (lo >= 64) lo -= 128;
      if (sv >= -64 && sv <= 63) begin
        b = '{field: 11'((sv & 127) << 4), immop: 4'b0001, last: 1'b1, err: 1'b0};
        exp_q.push_back(b);
      end else begin
        hi = ((int'(v) - lo) & 32'hFFFF) >> 7;
        b = '{field: 11'(hi << 2), immop: 4'b1010, last: (lo == 0), err: 1'b0};
        exp_q.push_back(b);
        if (lo != 0) begin
          b = '{field: 11'((int'(v) & 127) << 4), immop: 4'b0001, last: 1'b1, err: 1'b0};
          exp_q.push_back(b);
        end
      end
    end else begin
      ok  = 1'b1;
      w   = sv;
      if (s) begin
        if (v[0]) ok = 1'b0;
        w = sv / 2;
      end
      lim = (m == 2'd2) ? 256 : 64;
      if (w < -lim || w >= lim) ok = 1'b0;
      if (!ok) begin
        b = '{field: 11'd0, immop: {2'b00, m}, last: 1'b1, err: 1'b1};
      end else begin
        b.immop = {1'b0, s, (m == 2'd2), (m == 2'd0)};
        b.last  = 1'b1;
        b.err   = 1'b0;
        case (m)
          2'd0:    b.field = 11'((w & 127) << 4);
          2'd1:    b.field = 11'((((w >> 2) & 31) << 6) | (w & 3));
          default: b.field = 11'((w & 511) << 2);
        endcase
      end
      exp_q.push_back(b);
    end
  endfunction

  // Present one request, wait (bounded) for acceptance; returns the accept cycle.
  task automatic send(input logic [15:0] v, input logic [1:0] m, input logic s,
                      input bit directed, output int acc_cyc);
    acc_cyc  = -1;
    in_valid = 1'b1;
    in_value = v;
    in_mode  = m;
    in_scale = s;
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk);
      if (in_ready) begin
        if (directed) while (dir_q.size() > 0) exp_q.push_back(dir_q.pop_front());
        else model_push(v, m, s);
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    chk("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    for (t = 0; t < 3000 && exp_q.size() > 0; t++) @(negedge clk);
    chk("drain_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on each handshake and checks held beats stay stable.
  initial begin
    beat_t b;
    bit    hold_v;
    logic [16:0] hold_beat;
    hold_v = 1'b0;
    hold_beat = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_v = 1'b0;
        continue;
      end
      if (hold_v) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_beat", {out_field, out_immop, out_last, out_error}, hold_beat);
      end
      hold_v = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {out_field, out_immop}, 0);
        end else begin
          b = exp_q.pop_front();
          chk("field", out_field, b.field);
          chk("immop", out_immop, b.immop);
          chk("last", out_last, b.last);
          chk("error", out_error, b.err);
          chk("err_count", err_count, exp_err);
          if (b.err && exp_err < 255) exp_err++;
        end
      end else if (out_valid) begin
        hold_v = 1'b1;
        hold_beat = {out_field, out_immop, out_last, out_error};
      end
    end
  end

  initial begin
    int a, c, r;
    logic [15:0] v;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_beat", {out_field, out_immop, out_last, out_error}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;

    // Single-beat latency, then back-to-back requests with no bubble
    dpush(12'h400, 4'b0001, 1, 0);
    send(16'hFFC0, 2'd0, 1'b0, 1'b1, a);
    @(negedge clk);
    chk("latency_valid", out_valid, 1);
    @(posedge clk);
    #1;
    dpush(12'h241, 4'b0000, 1, 0);
    send(16'h0025, 2'd1, 1'b0, 1'b1, a);
    dpush(12'h3FC, 4'b0110, 1, 0);
    send(16'h01FE, 2'd2, 1'b1, 1'b1, c);
    chk("no_bubble_accept", c - a, 1);
    @(negedge clk);
    chk("no_bubble_valid", out_valid, 1);
    @(posedge clk);
    #1;
    dpush(0, 4'b0010, 1, 1);
    send(16'h01FF, 2'd2, 1'b1, 1'b1, a);
    dpush(0, 4'b0000, 1, 1);
    send(16'h0040, 2'd0, 1'b0, 1'b1, a);
    drain();
    @(negedge clk);
    chk("err_count_two", err_count, 2);
    @(posedge clk);
    #1;

    // LOADCONST sequences
    dpush(12'h004, 4'b1010, 0, 0);
    dpush(12'h500, 4'b0001, 1, 0);
    send(16'h0050, 2'd3, 1'b0, 1'b1, a);
    dpush(12'h400, 4'b1010, 1, 0);
    send(16'h8000, 2'd3, 1'b1, 1'b1, a);
    drain();

    // Backpressure on beat 1
    out_ready = 1'b0;
    dpush(12'h090, 4'b1010, 0, 0);
    dpush(12'h340, 4'b0001, 1, 0);
    send(16'h1234, 2'd3, 1'b0, 1'b1, a);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_beat", {out_field, out_immop, out_last}, {11'h090, 4'b1010, 1'b0});
      chk("bp_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    // Reset while beat 2 is pending
    out_ready = 1'b0;
    dpush(12'h090, 4'b1010, 0, 0);
    dpush(12'h340, 4'b0001, 1, 0);
    send(16'h1234, 2'd3, 1'b0, 1'b1, a);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    exp_err = 0;
    @(negedge clk);
    chk("rst_mid_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_err_count", err_count, 0);
    chk("rst_mid_in_ready_idle", in_ready, 1);
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_mid_no_beat", out_valid, 0);
    @(posedge clk);
    #1;

    // Randomized requests with random backpressure
    auto_rdy = 1'b1;
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 2);
      if (r == 0) v = 16'($urandom);
      else if (r == 1) v = 16'(int'($urandom_range(0, 1200)) - 600);
      else v = 16'($urandom) & 16'h807F;
      send(v, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0, a);
    end
    drain();
    auto_rdy = 1'b0;
    #2;
    out_ready = 1'b1;

    // Error counter saturation
    for (int i = 0; i < 300; i++) send(16'h0040, 2'd0, 1'b0, 1'b0, a);
    drain();
    @(posedge clk);
    @(negedge clk);
    chk("err_count_saturated", err_count, 255);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/immediate_encoder.md
Name: immediate_encoder

Overview:
- Reverse of the immediate generator: turns a 16-bit target value and an encoding mode into instruction immediate-field bits instr[10:0] plus the ImmOp code the generator needs to rebuild that value.
- LOADCONST mode splits any 16-bit constant into a two-beat sequence: an upper load (ImmOp shift-by-7) followed by a 7-bit add.
- Sits between the instruction-build/patch front end and the instruction buffer.
- Uses a valid/ready handshake on both sides.

Parameters:
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when in_valid&&in_ready
- in_value  input  16  target immediate value
- in_mode  input  2  0=IMM7A, 1=IMM7B, 2=IMM9, 3=LOADCONST
- in_scale  input  1  halfword scaling (ImmOp[2]); ignored in LOADCONST
- out_valid  output  1  beat valid
- out_ready  input  1  downstream accepts beat
- out_field  output  11  immediate bits for instr[10:0]; unused bits 0
- out_immop  output  4  ImmOp for this beat
- out_last  output  1  final beat of the request
- out_error  output  1  value not representable in the requested mode
- err_count  output  ERR_CNT_W  saturating count of error beats

Behaviour:
- Clocking and reset:
  - All state and outputs are registered on rising clk.
  - rst forces: state IDLE, out_valid=0, out_field=0, out_immop=0, out_last=0, out_error=0, err_count=0.
  - in_ready=0 while rst is high.
  - Reset mid-sequence drops any pending beat; no further beats are emitted.
- FSM states and transitions:
  - IDLE: no beat held.
  - BEAT1: first (or only) beat held.
  - BEAT2: LOADCONST low half held.
  - in_ready = (state==IDLE) || (out_valid && out_ready && out_last).
  - Latency: a request accepted in cycle N presents out_valid in cycle N+1.
- Handshake:
  - The beat presented at N+1 is held stable until out_ready.
  - On handshake of a non-last beat, the next beat appears in the following cycle.
  - On handshake of the last beat with a new request accepted the same cycle, the new request's beat appears next cycle with no bubble. Otherwise the FSM returns to IDLE.
- Encoding, v=in_value, s=in_scale, w=(s ? v>>>1 : v):
  - IMM7A: ImmOp={0,s,0,1}. Representable iff sext7(w[6:0])==w and (!s or v[0]==0). out_field[10:4]=w[6:0], [3:0]=0.
  - IMM7B: ImmOp={0,s,0,0}. Same representability test. out_field[10:6]=w[6:2], [5:2]=0, [1:0]=w[1:0].
  - IMM9: ImmOp={0,s,1,0}. Representable iff sext9(w[8:0])==w and (!s or v[0]==0). out_field[10:2]=w[8:0], [1:0]=0.
  - Not representable: one beat with out_error=1, out_field=0, out_immop=mode code, out_last=1.
  - err_count increments on each error-beat handshake and saturates at all-ones.
- LOADCONST (never errors):
  - lo = sext7(v[6:0]); hi = ((v - lo) >> 7)[8:0]. Arithmetic is mod 2^16.
  - If sext7(v[6:0])==v: single beat, IMM7A encoding, ImmOp=0001, last=1.
  - Otherwise beat 1: out_field[10:2]=hi, ImmOp=1010, last=(lo==0).
  - If lo!=0, beat 2: out_field[10:4]=v[6:0], ImmOp=0001, last=1.
  - Invariant: (hi<<7) + lo == v mod 2^16.
- Reserved: ImmOp[3]=1 together with ImmOp[2]=1 is never emitted.

Test Plan:
- mode0, v=0xFFC0, s=0 -> one beat: field=0x400, immop=0001, last=1, error=0, out_valid exactly one cycle after accept. mode1, v=0x0025 -> field=0x241, immop=0000.
- mode2, s=1, v=0x01FE -> field=0x3FC, immop=0110. mode2, s=1, v=0x01FF -> error=1, field=0, last=1, err_count=1. mode0, v=0x0040 -> error.
- mode3, v=0x1234 -> beat1 field=0x090, immop=1010, last=0; beat2 field=0x340, immop=0001, last=1.
- mode3, v=0x0050 -> beat1 field=0x004, immop=1010; beat2 field=0x500, immop=0001. mode3, v=0x8000 -> single beat field=0x400, immop=1010, last=1.
- Backpressure: out_ready low 3 cycles on beat1 -> beat1 outputs stable, in_ready=0. Last-beat handshake with in_valid high -> next request's beat appears the next cycle.
- rst asserted while BEAT2 pending -> next cycle out_valid=0, err_count=0, state IDLE. 300 forced error beats -> err_count saturates at 255.
